// File: rtl/ahb_sram_slave_pkg.sv
// Shared types for the AHB-Lite SRAM responder.
// Holds the transfer encodings and the responder state constants.
package ahb_sram_slave_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef logic [2:0] ahb_sram_state_t;

   localparam ahb_sram_state_t ST_IDLE     = 3'd0;
   localparam ahb_sram_state_t ST_WRITE    = 3'd1;
   localparam ahb_sram_state_t ST_RD_ISSUE = 3'd2;
   localparam ahb_sram_state_t ST_RD_DATA  = 3'd3;
   localparam ahb_sram_state_t ST_ERR1     = 3'd4;
   localparam ahb_sram_state_t ST_ERR2     = 3'd5;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus plus SRAM macro pins seen by the responder.
// The master modport is the bus/SRAM side, the slave modport is the responder.
interface ahb_sram_slave_if;

   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic        sram_cen;
   logic        sram_wen;
   logic [3:0]  sram_ben;
   logic [31:0] sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, sram_dout,
      output HRDATA, HREADYOUT, HRESP, sram_cen, sram_wen, sram_ben, sram_addr, sram_din
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, sram_dout,
      input  HRDATA, HREADYOUT, HRESP, sram_cen, sram_wen, sram_ben, sram_addr, sram_din
   );

endinterface

// File: rtl/ahb_lane_decode.sv
// Byte-lane decode: offset[1:0] and HSIZE to active-low byte enables and misalignment.
// Purely combinational, zero latency, no backpressure.
module ahb_lane_decode
   import ahb_sram_slave_pkg::*;
(
   input  logic [1:0] i_off,
   input  logic [2:0] i_size,
   output logic [3:0] o_ben,
   output logic       o_misalign
);

   always_comb begin
      o_ben      = 4'hF;
      o_misalign = 1'b0;
      case (i_size)
         HSIZE_BYTE: o_ben = ~(4'b0001 << i_off);
         HSIZE_HALF: begin
            o_ben      = i_off[1] ? 4'b0011 : 4'b1100;
            o_misalign = i_off[0];
         end
         HSIZE_WORD: begin
            o_ben      = 4'b0000;
            o_misalign = |i_off;
         end
         default: o_misalign = 1'b0;
      endcase
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder onto a single-port synchronous SRAM: writes zero-wait, reads one wait state,
// illegal transfers get a two-cycle ERROR; HREADYOUT low in RD_ISSUE and ERR1 stalls the bus.
module ahb_sram_slave
   import ahb_sram_slave_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0
)(
   input logic             HCLK,
   input logic             HRESET,
   ahb_sram_slave_if.slave bus
);

   ahb_sram_state_t r_state;
   ahb_sram_state_t w_next;
   logic [31:0]     r_addr;
   logic [3:0]      r_ben;
   logic [31:0]     w_off;
   logic [3:0]      w_ben;
   logic            w_misalign;
   logic            w_can_accept;
   logic            w_accept;
   logic            w_illegal;
   logic            w_wr;
   logic            w_rd;

   assign w_off = bus.HADDR - BASE_ADDR;

   ahb_lane_decode u_lane (
      .i_off      (w_off[1:0]),
      .i_size     (bus.HSIZE),
      .o_ben      (w_ben),
      .o_misalign (w_misalign)
   );

   // ERR2 is excluded: the master is cancelling whatever it presents there
   assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_WRITE) || (r_state == ST_RD_DATA);
   assign w_accept     = w_can_accept && bus.HSEL && bus.HREADY &&
                         ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
   assign w_illegal    = (bus.HSIZE > HSIZE_WORD) || w_misalign || (w_off >= MEM_BYTES);

   always_comb begin
      w_next = ST_IDLE;
      case (r_state)
         ST_RD_ISSUE: w_next = ST_RD_DATA;
         ST_ERR1:     w_next = ST_ERR2;
         default: begin
            if (w_accept) begin
               if (w_illegal)       w_next = ST_ERR1;
               else if (bus.HWRITE) w_next = ST_WRITE;
               else                 w_next = ST_RD_ISSUE;
            end
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_ben   <= 4'hF;
      end else begin
         r_state <= w_next;
         if (w_accept && !w_illegal) begin
            r_addr <= {w_off[31:2], 2'b00};
            r_ben  <= w_ben;
         end
      end
   end

   assign w_wr = (r_state == ST_WRITE);
   assign w_rd = (r_state == ST_RD_ISSUE);

   assign bus.HREADYOUT = !((r_state == ST_RD_ISSUE) || (r_state == ST_ERR1));
   assign bus.HRESP     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
   assign bus.HRDATA    = (r_state == ST_RD_DATA) ? bus.sram_dout : 32'h0;

   // SRAM pins are gated by state so an idle slave presents a quiet, reset-like macro interface
   assign bus.sram_cen  = !(w_wr || w_rd);
   assign bus.sram_wen  = !w_wr;
   assign bus.sram_ben  = w_wr ? r_ben : (w_rd ? 4'h0 : 4'hF);
   assign bus.sram_addr = (w_wr || w_rd) ? r_addr : 32'h0;
   assign bus.sram_din  = w_wr ? bus.HWDATA : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: pipelined AHB master, SRAM macro model and a byte-array reference memory.
module tb_ahb_sram_slave;

   localparam int          MEM_BYTES = 4096;
   localparam logic [31:0] BASE      = 32'h2000_0000;

   logic HCLK = 1'b0;
   logic HRESET = 1'b1;
   always #5 HCLK = ~HCLK;

   ahb_sram_slave_if bus ();

   ahb_sram_slave #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus.slave)
   );

   assign bus.HREADY = bus.HREADYOUT;

   // SRAM macro model
   logic [31:0] sram_mem [MEM_BYTES/4];
   logic [31:0] sram_q = 32'h0;
   assign bus.sram_dout = sram_q;

   always @(posedge HCLK) begin
      if (!bus.sram_cen) begin
         if (!bus.sram_wen) begin
            for (int i = 0; i < 4; i++)
               if (!bus.sram_ben[i]) sram_mem[bus.sram_addr[11:2]][8*i +: 8] = bus.sram_din[8*i +: 8];
            sram_q <= 32'h0;
         end else begin
            sram_q <= sram_mem[bus.sram_addr[11:2]];
         end
      end else begin
         sram_q <= 32'h0;
      end
   end

   // Reference model
   logic [7:0] ref_mem [MEM_BYTES];

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   xfer_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(xfer_t x);
      logic [31:0] off;
      logic [31:0] nb;
      off = x.addr - BASE;
      if (x.size > 3'd2) return 1'b0;
      nb = 32'd1 << x.size;
      return ((off % nb) == 32'd0) && (off < 32'(MEM_BYTES));
   endfunction

   // Lanes touched: every byte of the aligned word that lies inside [off, off+size)
   function automatic logic [3:0] exp_ben(xfer_t x);
      logic [31:0] off;
      logic [31:0] nb;
      logic [31:0] ba;
      logic [3:0]  b;
      off = x.addr - BASE;
      nb  = 32'd1 << x.size;
      for (int i = 0; i < 4; i++) begin
         ba   = (off & ~32'h3) + 32'(i);
         b[i] = !((ba >= off) && (ba < off + nb));
      end
      return b;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] off);
      int w;
      w = int'(off & ~32'h3);
      return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
   endfunction

   task automatic ref_write(input xfer_t x);
      logic [3:0] b;
      int w;
      b = exp_ben(x);
      w = int'((x.addr - BASE) & ~32'h3);
      for (int i = 0; i < 4; i++)
         if (!b[i]) ref_mem[w+i] = x.wdata[8*i +: 8];
   endtask

   task automatic push(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      xfer_t x;
      x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
      q.push_back(x);
   endtask

   task automatic drive_addr(input xfer_t a);
      bus.HSEL   = a.sel;
      bus.HTRANS = a.trans;
      bus.HWRITE = a.wr;
      bus.HSIZE  = a.size;
      bus.HADDR  = a.addr;
   endtask

   task automatic drive_idle();
      bus.HSEL   = 1'($urandom_range(0, 1));
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'($urandom_range(0, 1));
      bus.HSIZE  = 3'($urandom_range(0, 7));
      bus.HADDR  = $urandom();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " hreadyout"}, 32'(bus.HREADYOUT), 32'd1);
      chk({tag, " hresp"},     32'(bus.HRESP),     32'd0);
      chk({tag, " hrdata"},    bus.HRDATA,         32'd0);
      chk({tag, " cen"},       32'(bus.sram_cen),  32'd1);
      chk({tag, " wen"},       32'(bus.sram_wen),  32'd1);
      chk({tag, " ben"},       32'(bus.sram_ben),  32'hF);
      chk({tag, " addr"},      bus.sram_addr,      32'd0);
      chk({tag, " din"},       bus.sram_din,       32'd0);
   endtask

   // Pipelined master: next address phase overlaps the current data phase
   task automatic run_q();
      xfer_t dp, a;
      bit    have_dp, cancel, nxt_cancel, drove, ready, legal;
      int    dp_cyc, budget;
      have_dp = 1'b0; cancel = 1'b0; dp_cyc = 0; budget = 0;
      dp = '{default: '0};
      a  = '{default: '0};
      while ((q.size() > 0 || have_dp) && budget < 4000) begin
         budget++;
         @(posedge HCLK);
         #1;
         bus.HWDATA = (have_dp && dp.wr) ? dp.wdata : $urandom();
         drove = (q.size() > 0);
         if (drove) begin
            a = q[0];
            drive_addr(a);
         end else begin
            drive_idle();
         end
         @(negedge HCLK);
         ready = bus.HREADYOUT;
         legal = have_dp && is_legal(dp);
         if (have_dp) dp_cyc++;
         nxt_cancel = have_dp && !legal && (dp_cyc == 1);
         chk("sram_cen", 32'(bus.sram_cen), 32'(!(legal && dp_cyc == 1)));
         if (legal && dp_cyc == 1) begin
            chk("sram_wen",  32'(bus.sram_wen), 32'(!dp.wr));
            chk("sram_ben",  32'(bus.sram_ben), 32'(dp.wr ? exp_ben(dp) : 4'h0));
            chk("sram_addr", bus.sram_addr, (dp.addr - BASE) & ~32'h3);
            if (dp.wr) chk("sram_din", bus.sram_din, dp.wdata);
         end
         if (!have_dp) begin
            chk("idle hreadyout", 32'(bus.HREADYOUT), 32'd1);
            chk("idle hresp",     32'(bus.HRESP),     32'd0);
            chk("idle hrdata",    bus.HRDATA,         32'd0);
         end else begin
            chk("hresp", 32'(bus.HRESP), 32'(!legal));
            if (ready) begin
               chk("latency", 32'(dp_cyc), (legal && dp.wr) ? 32'd1 : 32'd2);
               if (legal && !dp.wr) chk("hrdata", bus.HRDATA, ref_word(dp.addr - BASE));
               else                 chk("hrdata zero", bus.HRDATA, 32'd0);
               if (legal && dp.wr) ref_write(dp);
               have_dp = 1'b0;
            end else begin
               chk("stall hrdata", bus.HRDATA, 32'd0);
            end
         end
         // an address shown during the second error cycle is ignored, so it is presented again
         if (drove && ready && !cancel) begin
            void'(q.pop_front());
            if (a.sel && a.trans[1]) begin
               dp      = a;
               have_dp = 1'b1;
               dp_cyc  = 0;
            end
         end
         cancel = nxt_cancel;
      end
      drive_idle();
      chk("queue drained", 32'(q.size() + int'(have_dp)), 32'd0);
   endtask

   initial begin
      xfer_t x;
      logic [31:0] off;
      int r;
      foreach (sram_mem[i]) sram_mem[i] = 32'h0;
      foreach (ref_mem[i])  ref_mem[i]  = 8'h0;
      drive_idle();
      bus.HWDATA = 32'h0;

      HRESET = 1'b1;
      repeat (2) @(posedge HCLK);
      #1;
      @(negedge HCLK);
      chk_reset_vals("reset");
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;

      push(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h8,  32'hDEADBEEF);
      push(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h8,  32'h0);
      push(1'b1, 2'b10, 1'b1, 3'd0, BASE + 32'hD,  32'h1234A578);
      push(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'hC,  32'h0);
      push(1'b1, 2'b10, 1'b0, 3'd1, BASE + 32'h3,  32'h0);
      push(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'(MEM_BYTES), 32'h0);
      push(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'h4,  32'h11223344);
      push(1'b1, 2'b11, 1'b0, 3'd2, BASE + 32'h4,  32'h0);
      push(1'b1, 2'b01, 1'b0, 3'd2, BASE + 32'h4,  32'h0);
      push(1'b0, 2'b10, 1'b1, 3'd2, BASE + 32'h4,  32'hFFFFFFFF);
      push(1'b1, 2'b10, 1'b1, 3'd1, BASE + 32'h12, 32'hCAFE5555);
      push(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 32'h0);
      push(1'b1, 2'b10, 1'b0, 3'd2, BASE - 32'h4,  32'h0);
      push(1'b1, 2'b10, 1'b1, 3'd3, BASE + 32'h0,  32'h0);
      run_q();

      // Reset while a read sits in its issue cycle
      @(posedge HCLK);
      #1;
      push(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h8, 32'h0);
      drive_addr(q[0]);
      void'(q.pop_front());
      @(posedge HCLK);
      #1;
      drive_idle();
      bus.HTRANS = 2'b00;
      HRESET = 1'b1;
      @(negedge HCLK);
      chk("rd_issue hreadyout", 32'(bus.HREADYOUT), 32'd0);
      chk("rd_issue cen",       32'(bus.sram_cen),  32'd0);
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      bus.HWDATA = 32'hFFFFFFFF;
      @(negedge HCLK);
      chk_reset_vals("mid reset");
      push(1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h8, 32'h0);
      run_q();

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         x.sel   = ($urandom_range(0, 19) != 0);
         x.trans = (r < 5) ? 2'b01 : ((r < 10) ? 2'b00 : 2'($urandom_range(2, 3)));
         x.wr    = 1'($urandom_range(0, 1));
         x.size  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         r = $urandom_range(0, 31);
         if (r == 0)      off = 32'(MEM_BYTES) + $urandom_range(0, 7);
         else if (r == 1) off = 32'hFFFF_FFFC;
         else             off = $urandom_range(0, 31);
         x.addr  = BASE + off;
         x.wdata = $urandom();
         q.push_back(x);
      end
      run_q();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1, "time limit");
   end

endmodule
